// File: rtl/hazard_ctrl_if.sv
// Decode/memory-side handshake bundle for hazard_ctrl: decoded operand info
// in, interlock/bypass controls out.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_BYP    = 3,
    parameter int SEL_W      = $clog2(NUM_BYP + 1)
);
    logic                  dec_valid;
    logic [REG_ADDR_W-1:0] dec_ra_addr;
    logic [REG_ADDR_W-1:0] dec_rb_addr;
    logic                  dec_ra_used;
    logic                  dec_rb_used;
    logic [REG_ADDR_W-1:0] dec_rc_addr;
    logic                  dec_we;
    logic                  dec_is_load;
    logic                  dec_branch_taken;
    logic                  mem_op;
    logic                  mem_ready;
    logic                  stall;
    logic                  bubble;
    logic                  flush;
    logic                  freeze;
    logic [SEL_W-1:0]      ra_sel;
    logic [SEL_W-1:0]      rb_sel;

    modport master (
        output dec_valid, dec_ra_addr, dec_rb_addr, dec_ra_used, dec_rb_used,
               dec_rc_addr, dec_we, dec_is_load, dec_branch_taken, mem_op, mem_ready,
        input  stall, bubble, flush, freeze, ra_sel, rb_sel
    );

    modport slave (
        input  dec_valid, dec_ra_addr, dec_rb_addr, dec_ra_used, dec_rb_used,
               dec_rc_addr, dec_we, dec_is_load, dec_branch_taken, mem_op, mem_ready,
        output stall, bubble, flush, freeze, ra_sel, rb_sel
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Beta pipeline interlock/bypass controller: scoreboard of in-flight writers,
// per-operand bypass select, load-use stall and memory-wait freeze.
// Optional HAZARD_PERF_EN adds saturating stall/freeze event counters.
module hazard_ctrl_opmatch #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_BYP    = 3,
    parameter int LD_STAGE   = 2,
    parameter int SEL_W      = $clog2(NUM_BYP + 1)
) (
    input  logic                               en,
    input  logic [REG_ADDR_W-1:0]              src,
    input  logic [NUM_BYP-1:0]                 sb_live,
    input  logic [NUM_BYP-1:0][REG_ADDR_W-1:0] sb_rc,
    input  logic [NUM_BYP-1:0]                 sb_ld,
    output logic [SEL_W-1:0]                   sel,
    output logic                               hazard
);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '1;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        sel    = '0;
        hazard = 1'b0;
        if (en && src != ZERO_REG) begin
            for (int i = NUM_BYP - 1; i >= 0; i--) begin
                if (sb_live[i] && sb_rc[i] == src) begin
                    hazard = sb_ld[i] && (i < LD_STAGE);
                    sel    = (sb_ld[i] && (i < LD_STAGE)) ? '0 : SEL_W'(i + 1);
                end
            end
        end
    end
endmodule

module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_BYP    = 3,
    parameter int LD_STAGE   = 2,
    parameter int SEL_W      = $clog2(NUM_BYP + 1)
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  freeze_cnt
`endif
);
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [REG_ADDR_W-1:0] rc;
        logic                  is_load;
    } sb_entry_t;

    sb_entry_t [NUM_BYP-1:0]                 sb;
    logic      [NUM_BYP-1:0]                 sb_live;
    logic      [NUM_BYP-1:0][REG_ADDR_W-1:0] sb_rc;
    logic      [NUM_BYP-1:0]                 sb_ld;

    logic      [1:0][REG_ADDR_W-1:0]         src_addr;
    logic      [1:0]                         src_en;
    logic      [1:0][SEL_W-1:0]              src_sel;
    logic      [1:0]                         src_haz;
    logic                                    stall;
    logic                                    freeze;

    for (genvar g = 0; g < NUM_BYP; g++) begin : g_sb
        assign sb_live[g] = sb[g].valid & sb[g].we;
        assign sb_rc[g]   = sb[g].rc;
        assign sb_ld[g]   = sb[g].is_load;
    end

    assign src_addr = {bus.dec_rb_addr, bus.dec_ra_addr};
    assign src_en   = {bus.dec_rb_used & bus.dec_valid, bus.dec_ra_used & bus.dec_valid};

    for (genvar g = 0; g < 2; g++) begin : g_op
        hazard_ctrl_opmatch #(
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_BYP    (NUM_BYP),
            .LD_STAGE   (LD_STAGE),
            .SEL_W      (SEL_W)
        ) u_match (
            .en      (src_en[g]),
            .src     (src_addr[g]),
            .sb_live (sb_live),
            .sb_rc   (sb_rc),
            .sb_ld   (sb_ld),
            .sel     (src_sel[g]),
            .hazard  (src_haz[g])
        );
    end

    assign freeze     = bus.mem_op & ~bus.mem_ready;
    assign stall      = (|src_haz) & ~freeze;
    assign bus.freeze = freeze;
    assign bus.stall  = stall;
    assign bus.bubble = stall;
    assign bus.flush  = bus.dec_branch_taken & bus.dec_valid & ~stall & ~freeze;
    assign bus.ra_sel = src_sel[0];
    assign bus.rb_sel = src_sel[1];

    // A stalled decode leaves a bubble in entry 0 while older entries advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb <= '0;
        end else if (!freeze) begin
            for (int i = 1; i < NUM_BYP; i++) sb[i] <= sb[i-1];
            if (stall || !bus.dec_valid)
                sb[0] <= '0;
            else
                sb[0] <= '{valid: 1'b1, we: bus.dec_we, rc: bus.dec_rc_addr,
                           is_load: bus.dec_is_load};
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)    stall_cnt  <= stall_cnt + 32'd1;
            if (freeze && freeze_cnt != '1)  freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: bypass distances, load-use stall,
// zero register, youngest-writer priority, freeze, reset and branch flush.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .NUM_BYP(3)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] freeze_cnt;
`endif

    hazard_ctrl #(.REG_ADDR_W(5), .NUM_BYP(3), .LD_STAGE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .freeze_cnt (freeze_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        bus.dec_valid        = 1'b0;
        bus.dec_ra_addr      = '0;
        bus.dec_rb_addr      = '0;
        bus.dec_ra_used      = 1'b0;
        bus.dec_rb_used      = 1'b0;
        bus.dec_rc_addr      = '0;
        bus.dec_we           = 1'b0;
        bus.dec_is_load      = 1'b0;
        bus.dec_branch_taken = 1'b0;
        #1;
    endtask

    task automatic issue(input int ra, input int ra_u, input int rb, input int rb_u,
                         input int rc, input int we, input int ld, input int br);
        bus.dec_valid        = 1'b1;
        bus.dec_ra_addr      = 5'(ra);
        bus.dec_ra_used      = 1'(ra_u);
        bus.dec_rb_addr      = 5'(rb);
        bus.dec_rb_used      = 1'(rb_u);
        bus.dec_rc_addr      = 5'(rc);
        bus.dec_we           = 1'(we);
        bus.dec_is_load      = 1'(ld);
        bus.dec_branch_taken = 1'(br);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    initial begin
        rst           = 1'b0;
        bus.mem_op    = 1'b0;
        bus.mem_ready = 1'b0;
        issue(1, 1, 1, 1, 0, 0, 0, 0);
        chk("rst_stall",  32'(bus.stall),  0);
        chk("rst_bubble", 32'(bus.bubble), 0);
        chk("rst_flush",  32'(bus.flush),  0);
        chk("rst_freeze", 32'(bus.freeze), 0);
        chk("rst_ra_sel", 32'(bus.ra_sel), 0);
        chk("rst_rb_sel", 32'(bus.rb_sel), 0);
        step();
        rst = 1'b1;

        // ADD r1, then readers of r1 walk through bypass distances 1..3, then RF
        issue(7, 1, 8, 1, 1, 1, 0, 0);
        chk("add_ra_sel", 32'(bus.ra_sel), 0);
        step();
        issue(1, 1, 1, 1, 10, 1, 0, 0);
        chk("byp1_ra_sel", 32'(bus.ra_sel), 1);
        chk("byp1_rb_sel", 32'(bus.rb_sel), 1);
        chk("byp1_stall",  32'(bus.stall),  0);
        step();
        issue(1, 1, 0, 0, 0, 0, 0, 0);
        chk("byp2_ra_sel", 32'(bus.ra_sel), 2);
        chk("byp2_rb_unused", 32'(bus.rb_sel), 0);
        step();
        chk("byp3_ra_sel", 32'(bus.ra_sel), 3);
        step();
        chk("byp_rf_ra_sel", 32'(bus.ra_sel), 0);

        // LD r2 followed by a user: load data usable only from stage 2
        drain();
        issue(0, 0, 0, 0, 11, 1, 0, 0);
        step();
        issue(3, 1, 0, 0, 2, 1, 1, 0);
        chk("ld_issue_stall", 32'(bus.stall), 0);
        step();
        issue(2, 1, 11, 1, 3, 1, 0, 0);
        chk("lu_stall0",  32'(bus.stall),  1);
        chk("lu_bubble0", 32'(bus.bubble), 1);
        chk("lu_ra_sel0", 32'(bus.ra_sel), 0);
        step();
        chk("lu_stall1",  32'(bus.stall),  1);
        step();
        chk("lu_stall2",  32'(bus.stall),  0);
        chk("lu_bubble2", 32'(bus.bubble), 0);
        chk("lu_ra_sel2", 32'(bus.ra_sel), 3);
        chk("lu_rb_sel2", 32'(bus.rb_sel), 0);

        // register 31 never matches
        drain();
        issue(0, 0, 0, 0, 31, 1, 0, 0);
        step();
        issue(31, 1, 31, 1, 0, 0, 0, 0);
        chk("zero_ra_sel", 32'(bus.ra_sel), 0);
        chk("zero_rb_sel", 32'(bus.rb_sel), 0);
        chk("zero_stall",  32'(bus.stall),  0);

        // writers of r4 at stages 0 and 2: youngest wins
        drain();
        issue(0, 0, 0, 0, 4, 1, 0, 0);
        step();
        issue(0, 0, 0, 0, 9, 1, 0, 0);
        step();
        issue(0, 0, 0, 0, 4, 1, 0, 0);
        step();
        issue(4, 1, 9, 1, 0, 0, 0, 0);
        chk("young_ra_sel", 32'(bus.ra_sel), 1);
        chk("young_rb_sel", 32'(bus.rb_sel), 2);

        // freeze in the middle of a load-use stall holds the scoreboard
        drain();
        issue(0, 0, 0, 0, 6, 1, 1, 0);
        step();
        issue(6, 1, 0, 0, 12, 1, 0, 0);
        chk("fz_pre_stall", 32'(bus.stall), 1);
        bus.mem_op    = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fz_freeze%0d", k), 32'(bus.freeze), 1);
            chk($sformatf("fz_stall%0d",  k), 32'(bus.stall),  0);
            chk($sformatf("fz_bubble%0d", k), 32'(bus.bubble), 0);
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("fz_ready_freeze", 32'(bus.freeze), 0);
        chk("fz_ready_stall",  32'(bus.stall),  1);
        bus.mem_op = 1'b0;
        step();
        chk("fz_post_stall1", 32'(bus.stall), 1);
        step();
        chk("fz_post_stall2", 32'(bus.stall), 0);
        chk("fz_post_ra_sel", 32'(bus.ra_sel), 3);
        step();

        // async reset during a freeze clears the scoreboard at once
        issue(12, 1, 0, 0, 0, 0, 0, 0);
        chk("rz_pre_ra_sel", 32'(bus.ra_sel), 1);
        bus.mem_op    = 1'b1;
        bus.mem_ready = 1'b0;
        rst           = 1'b0;
        #1;
        chk("rz_freeze", 32'(bus.freeze), 1);
        chk("rz_ra_sel", 32'(bus.ra_sel), 0);
        bus.mem_op = 1'b0;
        #1;
        chk("rz_unfreeze", 32'(bus.freeze), 0);
        step();
        rst = 1'b1;

        // taken branch whose operand is stalled must not redirect
        nop();
        issue(0, 0, 0, 0, 5, 1, 1, 0);
        step();
        nop();
        step();
        issue(5, 1, 0, 0, 0, 0, 0, 1);
        chk("br_stall", 32'(bus.stall), 1);
        chk("br_flush_stalled", 32'(bus.flush), 0);
        step();
        chk("br_nostall", 32'(bus.stall), 0);
        chk("br_flush", 32'(bus.flush), 1);
        chk("br_ra_sel", 32'(bus.ra_sel), 3);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt",  stall_cnt,  1);
        chk("perf_freeze_cnt", freeze_cnt, 0);
`endif
        nop();
        chk("br_flush_gone", 32'(bus.flush), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
